// File: rtl/hd63701_sci_pkg.sv
// Shared definitions for the HD63701-compatible serial communication interface.
// Holds the register offsets within the four-byte window, the TRCSR bit
// positions, the bit-rate multiplier table and the transmit/receive state
// encodings. No ports.
package hd63701_sci_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] OFF_RMCR  = 2'd0;
    localparam logic [1:0] OFF_TRCSR = 2'd1;
    localparam logic [1:0] OFF_RDR   = 2'd2;
    localparam logic [1:0] OFF_TDR   = 2'd3;

    // TRCSR bit positions
    localparam int BIT_RDRF = 7;
    localparam int BIT_ORFE = 6;
    localparam int BIT_TDRE = 5;
    localparam int BIT_RIE  = 4;
    localparam int BIT_RE   = 3;
    localparam int BIT_TIE  = 2;
    localparam int BIT_TE   = 1;
    localparam int BIT_WU   = 0;

    // Bit-period counters; wide enough for PERIOD0 x 256 up to 4M clocks
    localparam int CNT_W = 22;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Rate multipliers {1, 8, 64, 256} expressed as left-shift amounts
    function automatic logic [3:0] rate_shift(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'd0;
            2'd1:    return 4'd3;
            2'd2:    return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/hd63701_sci_fifo.sv
// Synchronous receive FIFO, DEPTH entries of WIDTH bits (DEPTH a power of two).
// Ports: clk, rst_n (async active-low), push/din write side, pop read side,
// full/empty status and head (current oldest entry, valid when not empty).
// A push while full is accepted only if a pop happens in the same cycle.
module hd63701_sci_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [1 << PTR_W];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/hd63701_sci_gen.sv
// HD63701-compatible SCI with selectable bit rate, mid-bit sampled receiver,
// framing/overrun detection and a parametrised receive FIFO.
// Ports: mcu_clx2 clock, mcu_rst_n async active-low reset; bus side mcu_ad,
// mcu_wr, mcu_do in and iod, en_sci out; serial rx in, tx out; te mirrors
// TRCSR.TE for pin muxing; mcu_irq0 interrupt request.
module hd63701_sci_gen
    import hd63701_sci_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter int          DATA_BITS = 8,
    parameter int          PERIOD0   = 64,
    parameter int          RX_DEPTH  = 1
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst_n,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic [7:0]  mcu_do,
    input  logic        rx,
    output logic        tx,
    output logic        te,
    output logic        mcu_irq0,
    output logic        en_sci,
    output logic [7:0]  iod
);
    localparam logic [16:0] END_ADDR = {1'b0, BASE_ADDR} + 17'd3;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    // Bus decode
    logic [1:0]       off;
    logic [15:0]      prev_ad_reg;
    logic             prev_wr_reg;
    logic             rd_access, wr_rmcr, wr_trcsr, wr_tdr, rdr_pop, arm;
    logic [7:0]       rmcr_reg, tdr_reg, trcsr_rd, rdr_rd;
    logic             rie_reg, re_reg, tie_reg, te_reg;
    logic             tdre_reg, orfe_reg, clr_armed_reg;
    logic [CNT_W-1:0] period, half;

    assign en_sci    = ({1'b0, mcu_ad} >= {1'b0, BASE_ADDR}) && ({1'b0, mcu_ad} <= END_ADDR);
    assign off       = mcu_ad[1:0] - BASE_ADDR[1:0];
    // A read is a new access only when the address moved or a write preceded it,
    // so a CPU holding the address for several cycles triggers side effects once
    assign rd_access = en_sci & ~mcu_wr & ((mcu_ad != prev_ad_reg) | prev_wr_reg);
    assign wr_rmcr   = en_sci & mcu_wr & (off == OFF_RMCR);
    assign wr_trcsr  = en_sci & mcu_wr & (off == OFF_TRCSR);
    assign wr_tdr    = en_sci & mcu_wr & (off == OFF_TDR);
    assign rdr_pop   = rd_access & (off == OFF_RDR) & clr_armed_reg;
    assign period    = CNT_W'(PERIOD0) << rate_shift(rmcr_reg[1:0]);
    assign half      = period >> 1;

    // FIFO
    logic                 fifo_full, fifo_empty, rx_push, rx_err, overrun;
    logic [DATA_BITS-1:0] fifo_head;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;

    assign arm     = rd_access & (off == OFF_TRCSR) & (~fifo_empty | orfe_reg);
    // Full and no pop this cycle: the incoming frame is lost
    assign overrun = rx_push & fifo_full & ~rdr_pop;

    hd63701_sci_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
        .clk   (mcu_clx2),
        .rst_n (mcu_rst_n),
        .push  (rx_push),
        .din   (rx_shift_reg),
        .pop   (rdr_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        trcsr_rd           = '0;
        trcsr_rd[BIT_RDRF] = ~fifo_empty;
        trcsr_rd[BIT_ORFE] = orfe_reg;
        trcsr_rd[BIT_TDRE] = tdre_reg;
        trcsr_rd[BIT_RIE]  = rie_reg;
        trcsr_rd[BIT_RE]   = re_reg;
        trcsr_rd[BIT_TIE]  = tie_reg;
        trcsr_rd[BIT_TE]   = te_reg;
        trcsr_rd[BIT_WU]   = 1'b0;
        rdr_rd             = fifo_empty ? 8'h00 : 8'(fifo_head);
        iod                = 8'h00;
        if (en_sci) begin
            case (off)
                OFF_RMCR:  iod = rmcr_reg;
                OFF_TRCSR: iod = trcsr_rd;
                OFF_RDR:   iod = rdr_rd;
                default:   iod = tdr_reg;
            endcase
        end
    end

    assign te       = te_reg;
    assign mcu_irq0 = (rie_reg & (~fifo_empty | orfe_reg)) | (tie_reg & tdre_reg);

    // Transmitter
    tx_state_t            tx_state_reg, tx_state_next;
    logic [CNT_W-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_load, tx_reg, tx_next;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: tx_load = te_reg & ~tdre_reg;
            TX_START: begin
                if (tx_cnt_reg == '0) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = period - 1'b1;
                    tx_bit_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == '0) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    tx_cnt_next   = period - 1'b1;
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    if (tx_bit_reg == LAST_BIT) begin
                        tx_state_next = TX_STOP;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
            default: begin
                if (tx_cnt_reg == '0) begin
                    // Chain straight into the next start bit when data is waiting
                    tx_load       = te_reg & ~tdre_reg;
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
        endcase
        if (tx_load) begin
            tx_state_next = TX_START;
            tx_cnt_next   = period - 1'b1;
            tx_shift_next = tdr_reg[DATA_BITS-1:0];
        end
        // Registered line level keeps tx glitch-free
        case (tx_state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = tx_shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

    // Receiver
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic             rx_s1_reg, rx_s2_reg, rx_s3_reg;
    logic             brk_reg, brk_next;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        brk_next      = brk_reg;
        rx_push       = 1'b0;
        rx_err        = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (~rx_s2_reg & rx_s3_reg) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = half - 1'b1;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == '0) begin
                    // Line back high at mid start bit: noise, not a frame
                    rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
                    rx_cnt_next   = period - 1'b1;
                    rx_bit_next   = '0;
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_shift_next = {rx_s2_reg, rx_shift_reg[DATA_BITS-1:1]};
                    rx_cnt_next   = period - 1'b1;
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == LAST_BIT) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
            default: begin
                if (brk_reg) begin
                    // Break/framing error: hold off until the line idles
                    if (rx_s2_reg) begin
                        rx_state_next = RX_IDLE;
                        brk_next      = 1'b0;
                    end
                end else if (rx_cnt_reg == '0) begin
                    if (rx_s2_reg) begin
                        rx_push       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_err   = 1'b1;
                        brk_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
        endcase
        if (!re_reg) begin
            rx_state_next = RX_IDLE;
            brk_next      = 1'b0;
            rx_push       = 1'b0;
            rx_err        = 1'b0;
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            prev_ad_reg   <= '0;
            prev_wr_reg   <= 1'b1;
            rmcr_reg      <= '0;
            tdr_reg       <= '0;
            rie_reg       <= 1'b0;
            re_reg        <= 1'b0;
            tie_reg       <= 1'b0;
            te_reg        <= 1'b0;
            tdre_reg      <= 1'b1;
            orfe_reg      <= 1'b0;
            clr_armed_reg <= 1'b0;
        end else begin
            prev_ad_reg <= mcu_ad;
            prev_wr_reg <= mcu_wr;
            if (wr_rmcr) rmcr_reg <= mcu_do;
            if (wr_tdr)  tdr_reg  <= mcu_do;
            if (wr_trcsr) begin
                rie_reg <= mcu_do[BIT_RIE];
                re_reg  <= mcu_do[BIT_RE];
                tie_reg <= mcu_do[BIT_TIE];
                te_reg  <= mcu_do[BIT_TE];
            end
            // A write in the load cycle keeps the new byte pending
            if (wr_tdr)       tdre_reg <= 1'b0;
            else if (tx_load) tdre_reg <= 1'b1;
            if (rx_err | overrun) orfe_reg <= 1'b1;
            else if (rdr_pop)     orfe_reg <= 1'b0;
            if (arm)          clr_armed_reg <= 1'b1;
            else if (rdr_pop) clr_armed_reg <= 1'b0;
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            brk_reg      <= 1'b0;
            rx_s1_reg    <= 1'b1;
            rx_s2_reg    <= 1'b1;
            rx_s3_reg    <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            brk_reg      <= brk_next;
            rx_s1_reg    <= rx;
            rx_s2_reg    <= rx_s1_reg;
            rx_s3_reg    <= rx_s2_reg;
        end
    end

endmodule

// File: tb/tb_hd63701_sci_gen.sv
// Directed bench for hd63701_sci_gen: two instances share the bus and rx line,
// one with a single-entry receive FIFO and one with four entries.
module tb_hd63701_sci_gen;
    localparam logic [15:0] A_RMCR  = 16'h0010;
    localparam logic [15:0] A_TRCSR = 16'h0011;
    localparam logic [15:0] A_RDR   = 16'h0012;
    localparam logic [15:0] A_TDR   = 16'h0013;
    localparam logic [15:0] A_IDLE  = 16'h0000;
    localparam int          BP      = 512;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] mcu_ad = A_IDLE;
    logic        mcu_wr = 1'b0;
    logic [7:0]  mcu_do = 8'h00;
    logic        rx     = 1'b1;
    logic        tx1, te1, irq1, en1, tx4, te4, irq4, en4;
    logic [7:0]  iod1, iod4;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    hd63701_sci_gen #(.RX_DEPTH(1)) u_dut1 (
        .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(mcu_ad), .mcu_wr(mcu_wr),
        .mcu_do(mcu_do), .rx(rx), .tx(tx1), .te(te1), .mcu_irq0(irq1),
        .en_sci(en1), .iod(iod1)
    );
    hd63701_sci_gen #(.RX_DEPTH(4)) u_dut4 (
        .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(mcu_ad), .mcu_wr(mcu_wr),
        .mcu_do(mcu_do), .rx(rx), .tx(tx4), .te(te4), .mcu_irq0(irq4),
        .en_sci(en4), .iod(iod4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: 0x%02h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        mcu_ad = a;
        mcu_wr = 1'b1;
        mcu_do = d;
        @(negedge clk);
        mcu_wr = 1'b0;
        mcu_ad = A_IDLE;
        $display("wr   0x%04h <= 0x%02h (cycle %0d)", a, d, cyc);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d1, output logic [7:0] d4);
        mcu_ad = a;
        mcu_wr = 1'b0;
        #1;
        d1 = iod1;
        d4 = iod4;
        @(negedge clk);
        mcu_ad = A_IDLE;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        idle(BP);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BP);
        end
        rx = stop;
        idle(BP);
        rx = 1'b1;
        $display("rx   frame 0x%02h stop %0b (cycle %0d)", d, stop, cyc);
    endtask

    initial begin
        logic [7:0] r1, r4;
        logic [7:0] pat;
        int         t0;

        // Reset state
        idle(3);
        check("rst_tx", 8'(tx1), 8'h01);
        check("rst_te", 8'(te1), 8'h00);
        check("rst_irq", 8'(irq1), 8'h00);
        bus_rd(A_TRCSR, r1, r4);
        check("rst_trcsr1", r1, 8'h20);
        check("rst_trcsr4", r4, 8'h20);
        rst_n = 1'b1;
        idle(1);
        bus_rd(A_RMCR, r1, r4);
        check("rst_rmcr", r1, 8'h00);

        // Address window
        mcu_ad = 16'h0013; #1;
        check("en_top", 8'(en1), 8'h01);
        mcu_ad = 16'h0014; #1;
        check("en_above", 8'(en4), 8'h00);
        mcu_ad = 16'h000F; #1;
        check("en_below", 8'(en1), 8'h00);
        mcu_ad = A_IDLE;
        idle(1);

        // Rate 01 -> 512 clocks/bit; upper RMCR bits stored
        bus_wr(A_RMCR, 8'hFD);
        bus_rd(A_RMCR, r1, r4);
        check("rmcr_rb", r4, 8'hFD);

        // Transmit 0xA5
        bus_wr(A_TRCSR, 8'h02);
        check("te_set", 8'(te1), 8'h01);
        check("te_set4", 8'(te4), 8'h01);
        bus_wr(A_TDR, 8'hA5);
        check("tx_idle_wr", 8'(tx1), 8'h01);
        bus_rd(A_TRCSR, r1, r4);
        check("tdre_clr", r1, 8'h02);
        t0 = cyc;
        check("tx_start", 8'(tx1), 8'h00);
        bus_rd(A_TRCSR, r1, r4);
        check("tdre_load", r1, 8'h22);
        wait_until(t0 + BP - 1);
        check("tx_start_end", 8'(tx1), 8'h00);
        wait_until(t0 + BP);
        check("tx_bit0_edge", 8'(tx1), 8'h01);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            wait_until(t0 + BP * (i + 1) + BP / 2);
            check($sformatf("tx_bit%0d", i), 8'(tx1), 8'(pat[i]));
        end
        wait_until(t0 + 9 * BP + BP / 2);
        check("tx_stop", 8'(tx1), 8'h01);
        wait_until(t0 + 10 * BP + BP / 2);
        check("tx_after", 8'(tx1), 8'h01);
        check("tx4_after", 8'(tx4), 8'h01);

        // Receive 0x3C
        bus_wr(A_TRCSR, 8'h08);
        send_frame(8'h3C, 1'b1);
        idle(4);
        bus_rd(A_TRCSR, r1, r4);
        check("rx_rdrf", r1, 8'hA8);
        bus_rd(A_RDR, r1, r4);
        check("rx_data1", r1, 8'h3C);
        check("rx_data4", r4, 8'h3C);
        bus_rd(A_TRCSR, r1, r4);
        check("rx_cleared", r1, 8'h28);

        // Two frames without reading: overrun on the single-entry FIFO
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        bus_rd(A_TRCSR, r1, r4);
        check("ovr_trcsr1", r1, 8'hE8);
        check("ovr_trcsr4", r4, 8'hA8);
        bus_rd(A_RDR, r1, r4);
        check("ovr_rdr1", r1, 8'h11);
        check("ovr_rdr4", r4, 8'h11);
        bus_rd(A_TRCSR, r1, r4);
        check("ovr_clr1", r1, 8'h28);
        check("ovr_more4", r4, 8'hA8);
        bus_rd(A_RDR, r1, r4);
        check("ovr_empty1", r1, 8'h00);
        check("ovr_rdr4b", r4, 8'h22);
        bus_rd(A_TRCSR, r1, r4);
        check("ovr_done4", r4, 8'h28);

        // Framing error: stop bit 0
        send_frame(8'h55, 1'b0);
        idle(4);
        bus_rd(A_TRCSR, r1, r4);
        check("fe_trcsr1", r1, 8'h68);
        check("fe_trcsr4", r4, 8'h68);
        bus_rd(A_RDR, r1, r4);
        check("fe_nopush", r4, 8'h00);
        bus_rd(A_TRCSR, r1, r4);
        check("fe_clr", r1, 8'h28);

        // 100-clock glitch is a false start
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(1200);
        bus_rd(A_TRCSR, r1, r4);
        check("glitch", r4, 8'h28);

        // Fill the four-entry FIFO
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
        idle(4);
        bus_rd(A_RDR, r1, r4);
        check("noarm_rdr4", r4, 8'h01);
        idle(1);
        bus_rd(A_RDR, r1, r4);
        check("noarm_again4", r4, 8'h01);
        check("noarm_again1", r1, 8'h01);
        bus_rd(A_TRCSR, r1, r4);
        check("full_trcsr1", r1, 8'hE8);
        check("full_trcsr4", r4, 8'hA8);
        // Fifth frame with a pop during reception
        fork
            send_frame(8'h05, 1'b1);
            begin
                idle(2000);
                bus_rd(A_RDR, r1, r4);
                check("mid_pop4", r4, 8'h01);
                check("mid_pop1", r1, 8'h01);
            end
        join
        idle(4);
        bus_rd(A_TRCSR, r1, r4);
        check("no_ovr4", r4, 8'hA8);
        check("no_ovr1", r1, 8'hA8);
        for (int k = 2; k <= 5; k++) begin
            bus_rd(A_RDR, r1, r4);
            check($sformatf("drain_rdr4_%0d", k), r4, 8'(k));
            check($sformatf("drain_rdr1_%0d", k), r1, (k == 2) ? 8'h05 : 8'h00);
            bus_rd(A_TRCSR, r1, r4);
            check($sformatf("drain_trcsr4_%0d", k), r4, (k < 5) ? 8'hA8 : 8'h28);
            check($sformatf("drain_trcsr1_%0d", k), r1, 8'h28);
        end

        // Interrupts
        bus_wr(A_TRCSR, 8'h04);
        check("irq_tie", 8'(irq1), 8'h01);
        bus_wr(A_TRCSR, 8'h18);
        check("irq_off", 8'(irq4), 8'h00);
        send_frame(8'h77, 1'b1);
        idle(4);
        check("irq_rx1", 8'(irq1), 8'h01);
        check("irq_rx4", 8'(irq4), 8'h01);

        // Reset in the middle of TX and RX frames
        bus_wr(A_TRCSR, 8'h1A);
        bus_wr(A_TDR, 8'h00);
        fork
            send_frame(8'h99, 1'b1);
            begin
                idle(1000);
                check("tx_busy", 8'(tx1), 8'h00);
                rst_n = 1'b0;
                #1;
                check("mid_rst_tx", 8'(tx1), 8'h01);
                check("mid_rst_irq1", 8'(irq1), 8'h00);
                check("mid_rst_irq4", 8'(irq4), 8'h00);
                bus_rd(A_TRCSR, r1, r4);
                check("mid_rst_trcsr", r1, 8'h20);
                rst_n = 1'b1;
            end
        join
        idle(4);
        bus_rd(A_TRCSR, r1, r4);
        check("post_rst_trcsr", r4, 8'h20);
        check("post_rst_tx", 8'(tx1), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
